// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants, MDU state encoding and small arithmetic helpers for ex_muldiv.
package ex_muldiv_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic is_md;      // MULT/MULTU/DIV/DIVU
        logic is_div;
        logic is_signed;
        logic mthi;
        logic mtlo;
        logic mfhi;
        logic mflo;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [5:0] opcode, input logic [5:0] func);
        md_dec_t d;
        d = '0;
        if (opcode == OPC_SPECIAL) begin
            case (func)
                FUNC_MFHI:  d.mfhi = 1'b1;
                FUNC_MTHI:  d.mthi = 1'b1;
                FUNC_MFLO:  d.mflo = 1'b1;
                FUNC_MTLO:  d.mtlo = 1'b1;
                FUNC_MULT:  begin d.is_md = 1'b1; d.is_signed = 1'b1; end
                FUNC_MULTU: d.is_md = 1'b1;
                FUNC_DIV:   begin d.is_md = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
                FUNC_DIVU:  begin d.is_md = 1'b1; d.is_div = 1'b1; end
                default:    d = '0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage bundle between the pipeline (master) and the multiply/divide unit (slave).
interface ex_muldiv_if;
    logic        flush;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_req;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output flush, ex_opcode, ex_func, op_a, op_b,
        input  stall_req, hilo_rdata, hi_o, lo_o
    );

    modport slave (
        input  flush, ex_opcode, ex_func, op_a, op_b,
        output stall_req, hilo_rdata, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per step, sequenced by ex_muldiv.
module div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quo_next_o,
    output logic [W-1:0] rem_next_o
);

    logic [W-1:0] rem_q;
    logic [W-1:0] quo_q;
    logic [W-1:0] dvs_q;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         fits;

    // A set carry-out bit means the trial value already exceeds any W-bit divisor,
    // and the wrapped W-bit difference is then still exact.
    assign shifted    = {rem_q, quo_q[W-1]};
    assign diff       = shifted[W-1:0] - dvs_q;
    assign fits       = shifted[W] | (shifted[W-1:0] >= dvs_q);
    assign rem_next_o = fits ? diff : shifted[W-1:0];
    assign quo_next_o = {quo_q[W-2:0], fits};

    // NOTE: datapath registers carry no reset; they are always loaded on start before being read.
    always_ff @(posedge clk) begin
        if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_next_o;
            quo_q <= quo_next_o;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with HI/LO. Define MULDIV_MULTICYCLE_MULT_EN to run MULT/MULTU
// through the iterative FSM path instead of the single-cycle combinational multiplier.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    md_dec_t          dec;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        sign_a_q, sign_b_q, b_zero_q;
    logic [31:0] a_raw_q;

    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic        start, fsm_start, mult_now, fsm_is_div, last_iter, stall;
    logic [31:0] quo_next, rem_next, div_lo, div_hi;
    logic [63:0] mult_prod;

    assign dec    = md_decode(bus.ex_opcode, bus.ex_func);
    assign sign_a = dec.is_signed & bus.op_a[31];
    assign sign_b = dec.is_signed & bus.op_b[31];
    assign mag_a  = cneg32(bus.op_a, sign_a);
    assign mag_b  = cneg32(bus.op_b, sign_b);
    assign start  = dec.is_md && (state_q == MDU_IDLE) && !bus.flush;

`ifdef MULDIV_MULTICYCLE_MULT_EN
    logic        is_div_q;
    logic [63:0] p_q;
    logic [31:0] mcand_q;
    logic [32:0] p_sum;

    assign fsm_start  = start;
    assign mult_now   = 1'b0;
    assign fsm_is_div = is_div_q;

    // Shift-add: add the multiplicand into the upper half when the current LSB is set, then shift right.
    assign p_sum     = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign mult_prod = cneg64({p_sum, p_q[31:1]}, sign_a_q ^ sign_b_q);

    always_ff @(posedge clk) begin
        if (fsm_start) begin
            is_div_q <= dec.is_div;
            p_q      <= {32'd0, mag_b};
            mcand_q  <= mag_a;
        end else if (state_q == MDU_BUSY) begin
            p_q <= {p_sum, p_q[31:1]};
        end
    end
`else
    assign fsm_start  = start & dec.is_div;
    assign mult_now   = start & ~dec.is_div;
    assign fsm_is_div = 1'b1;
    assign mult_prod  = cneg64({32'd0, mag_a} * {32'd0, mag_b}, sign_a ^ sign_b);
`endif

    always_ff @(posedge clk) begin
        if (fsm_start) begin
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            a_raw_q  <= bus.op_a;
            b_zero_q <= (bus.op_b == 32'd0);
        end
    end

    div_core #(
        .W (32)
    ) u_div_core (
        .clk        (clk),
        .load_i     (fsm_start),
        .step_i     (state_q == MDU_BUSY),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_next_o (quo_next),
        .rem_next_o (rem_next)
    );

    // Quotient takes the XOR of the signs, remainder follows the dividend; x/0 bypasses the fix-up.
    assign div_lo    = b_zero_q ? 32'hFFFF_FFFF : cneg32(quo_next, sign_a_q ^ sign_b_q);
    assign div_hi    = b_zero_q ? a_raw_q       : cneg32(rem_next, sign_a_q);
    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: every _d and stall gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (fsm_start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = '0;
                    stall   = 1'b1;
                end else if (mult_now) begin
                    hi_d = mult_prod[63:32];
                    lo_d = mult_prod[31:0];
                end else if (!bus.flush) begin
                    if (dec.mthi) hi_d = bus.op_a;
                    if (dec.mtlo) lo_d = bus.op_a;
                end
            end
            MDU_BUSY: begin
                if (bus.flush) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = MDU_DONE;
                        if (fsm_is_div) begin
                            hi_d = div_hi;
                            lo_d = div_lo;
                        end else begin
                            hi_d = mult_prod[63:32];
                            lo_d = mult_prod[31:0];
                        end
                    end
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    assign bus.stall_req  = rst & stall;
    assign bus.hilo_rdata = !rst     ? 32'd0 :
                            dec.mfhi ? hi_q  :
                            dec.mflo ? lo_q  : 32'd0;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv; expected values are hand-computed constants.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

`ifdef MULDIV_MULTICYCLE_MULT_EN
    localparam int MULT_STALLS = 33;
`else
    localparam int MULT_STALLS = 0;
`endif
    localparam int         DIV_STALLS = 33;
    localparam logic [5:0] OPC_NOP    = 6'h3F;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ex_muldiv_if bus ();

    ex_muldiv u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] opc, input logic [5:0] func,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        bus.ex_opcode = opc;
        bus.ex_func   = func;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.flush     = fl;
    endtask

    task automatic nop_cycle();
        @(negedge clk);
        drive(OPC_NOP, 6'h00, 32'd0, 32'd0, 1'b0);
        #1;
    endtask

    // Holds the instruction in EX while stall_req is high, as the frozen pipeline would.
    task automatic issue(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        @(negedge clk);
        drive(OPC_SPECIAL, func, a, b, 1'b0);
        #1;
        stalls = 0;
        while (bus.stall_req === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] func,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_stalls, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls;
        issue(func, a, b, stalls);
        check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
        if (stalls == 0) nop_cycle();
        check({tag, " hi"}, bus.hi_o, exp_hi);
        check({tag, " lo"}, bus.lo_o, exp_lo);
        nop_cycle();
        check({tag, " no restart"}, {31'd0, bus.stall_req}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        drive(OPC_NOP, 6'h00, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'd0, bus.stall_req}, 32'd0);
        check("reset hi", bus.hi_o, 32'd0);
        check("reset lo", bus.lo_o, 32'd0);
        rst = 1'b1;

        run_op("divu 100/7", FUNC_DIVU, 32'd100, 32'd7, DIV_STALLS, 32'd2, 32'd14);
        run_op("div -7/2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2, DIV_STALLS, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 5/0", FUNC_DIV, 32'd5, 32'd0, DIV_STALLS, 32'd5, 32'hFFFF_FFFF);
        run_op("div min/-1", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALLS, 32'd0, 32'h8000_0000);
        run_op("mult -1*3", FUNC_MULT, 32'hFFFF_FFFF, 32'd3, MULT_STALLS, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("multu", FUNC_MULTU, 32'hFFFF_FFFF, 32'd3, MULT_STALLS, 32'd2, 32'hFFFF_FFFD);

        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        check("mflo rdata", bus.hilo_rdata, 32'hFFFF_FFFD);

        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_MTHI, 32'h0000_ABCD, 32'd0, 1'b0);
        #1;
        check("mthi no stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        check("mfhi rdata", bus.hilo_rdata, 32'h0000_ABCD);

        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_MTLO, 32'h0000_1234, 32'd0, 1'b1);
        nop_cycle();
        check("mtlo flushed", bus.lo_o, 32'hFFFF_FFFD);

        // Flush in the tenth BUSY cycle of a DIV.
        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_DIV, 32'd100, 32'd7, 1'b0);
        #1;
        check("flush op stalls", {31'd0, bus.stall_req}, 32'd1);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush drops stall", {31'd0, bus.stall_req}, 32'd0);
        nop_cycle();
        check("after flush stall", {31'd0, bus.stall_req}, 32'd0);
        check("after flush hi", bus.hi_o, 32'h0000_ABCD);
        check("after flush lo", bus.lo_o, 32'hFFFF_FFFD);
        run_op("divu 1001/10", FUNC_DIVU, 32'd1001, 32'd10, DIV_STALLS, 32'd1, 32'd100);

        // Reset held for two cycles in the middle of a divide.
        @(negedge clk);
        drive(OPC_SPECIAL, FUNC_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        drive(OPC_SPECIAL, FUNC_MFHI, 32'd0, 32'd0, 1'b1);
        #1;
        check("in reset stall", {31'd0, bus.stall_req}, 32'd0);
        check("in reset rdata", bus.hilo_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(OPC_NOP, 6'h00, 32'd0, 32'd0, 1'b0);
        #1;
        check("post reset stall", {31'd0, bus.stall_req}, 32'd0);
        check("post reset hi", bus.hi_o, 32'd0);
        check("post reset lo", bus.lo_o, 32'd0);
        run_op("divu 9/4", FUNC_DIVU, 32'd9, 32'd4, DIV_STALLS, 32'd1, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
